ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 32, the number of configuration flip-flops in the driven ccff chain (legal range 1..4096).
REQ-002 SHALL have parameter WORD_W, default 8, the width of the bitstream and readback words.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single programming clock; all state is clocked on its rising edge.
REQ-004 SHALL have port pResetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a chain load.
REQ-006 SHALL have port cfg_data, input, WORD_W bits: bitstream word, MSB shifted first.
REQ-007 SHALL have port cfg_valid, input, 1 bit: cfg_data valid.
REQ-008 SHALL have port cfg_ready, output, 1 bit: loader accepts cfg_data this cycle.
REQ-009 SHALL have port ccff_head, output, 1 bit: serial bit into the chain head.
REQ-010 SHALL have port config_enable, output, 1 bit: chain shift enable; the chain advances one bit on each edge where it is high.
REQ-011 SHALL have port ccff_tail, input, 1 bit: chain tail, i.e. the previous chain contents (readback).
REQ-012 SHALL have port rb_data, output, WORD_W bits: collected readback word.
REQ-013 SHALL have port rb_valid, output, 1 bit: one-cycle strobe qualifying rb_data.
REQ-014 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at load completion.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE: cfg_ready=0, config_enable=0, busy=0; start=1 -> LOAD, clear bit counter; start in any other state SHALL be ignored.
REQ-018 LOAD: cfg_ready=1, config_enable=0; cfg_valid&cfg_ready at edge -> word latched, SHIFT; otherwise remain in LOAD (stall) with the chain frozen.
REQ-019 SHIFT: each cycle config_enable=1, ccff_head=the current word bit (MSB first); at the edge, advance bit index, bit counter +1, sample ccff_tail into the readback shifter.
REQ-020 cfg_ready SHALL also be 1 in the last bit cycle of a word when bits remain; acceptance then continues SHIFT with no bubble (full throughput); no acceptance -> LOAD.
REQ-021 When the bit counter reaches CHAIN_LEN, the state SHALL go to DONE regardless of word position; unused low bits of the final word are discarded; cfg_ready=0 in that cycle.
REQ-022 ccff_head and config_enable SHALL be registered outputs; they SHALL be stable for the whole cycle in which the chain samples them.
REQ-023 Readback: ccff_tail bits SHALL be packed MSB first; rb_valid SHALL pulse the cycle after each WORD_W-th bit is sampled and after the final bit; a partial final word is left-justified and zero-padded.
REQ-024 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; busy=1 in LOAD and SHIFT only.
REQ-025 Total config_enable-high cycles per load SHALL equal CHAIN_LEN exactly, independent of stalls.

Reset
REQ-026 pResetn=0 SHALL immediately force IDLE with cfg_ready=0, config_enable=0, ccff_head=0, rb_data=0, rb_valid=0, busy=0, done=0, and all counters cleared.
REQ-027 Reset mid-load SHALL abandon the load with no further chain shifts; the next start restarts from bit 0.

Verification
REQ-028 CHAIN_LEN=16, chain model preloaded 0xFFFF, words 0xA5,0x3C streamed without gaps -> 16 consecutive config_enable cycles, ccff_head 1010010100111100, rb words 0xFF,0xFF, single done pulse.
REQ-029 Repeat load with 0x00,0x00 -> rb words 0xA5,0x3C (loopback integrity).
REQ-030 CHAIN_LEN=12, words 0xAB,0xCD -> 12 shifts, bits 10101011 1100, rb second word left-justified 4 bits with low nibble 0000, 0xD bits never driven.
REQ-031 cfg_valid held low for 3 cycles between words -> config_enable=0 for those 3 cycles, chain contents unchanged, final state identical to the gap-free run.
REQ-032 pResetn low after 5 shifted bits -> config_enable=0 at once, no done; a fresh start shifts all 16 bits correctly.
REQ-033 start pulsed during SHIFT -> ignored; exactly CHAIN_LEN shifts and one done pulse.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a ccff chain on prog_clk,
// while packing the bits shifted out of the chain tail into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pResetn,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RBN_W = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [RBN_W-1:0] FULL_RB  = RBN_W'(WORD_W);

  logic [1:0]        st;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bidx;
  logic [WORD_W-1:0] sh;
  logic [WORD_W-1:0] rb_sh;
  logic [RBN_W-1:0]  rb_n;

  logic [CNT_W-1:0]  cnt_nx;
  logic [RBN_W-1:0]  rb_n_nx;
  logic [WORD_W-1:0] rb_sh_nx;
  logic              last_bit;
  logic              chain_end;

  always_comb begin
    cnt_nx    = cnt + CNT_W'(1);
    rb_n_nx   = rb_n + RBN_W'(1);
    rb_sh_nx  = (rb_sh << 1) | WORD_W'(ccff_tail);
    last_bit  = (bidx == LAST_BIT);
    chain_end = (cnt_nx == LAST_CNT);
  end

  // next word is only wanted if the chain still has room after this bit
  assign cfg_ready = (st == S_LOAD) |
                     ((st == S_SHIFT) & last_bit & ~chain_end);
  assign busy      = (st == S_LOAD) | (st == S_SHIFT);
  assign done      = (st == S_DONE);

  always_ff @(posedge prog_clk or negedge pResetn) begin
    if (!pResetn) begin
      st            <= S_IDLE;
      cnt           <= '0;
      bidx          <= '0;
      sh            <= '0;
      rb_sh         <= '0;
      rb_n          <= '0;
      rb_data       <= '0;
      rb_valid      <= 1'b0;
      ccff_head     <= 1'b0;
      config_enable <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (start) begin
            st    <= S_LOAD;
            cnt   <= '0;
            bidx  <= '0;
            rb_n  <= '0;
            rb_sh <= '0;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            st            <= S_SHIFT;
            config_enable <= 1'b1;
            ccff_head     <= cfg_data[WORD_W-1];
            sh            <= cfg_data << 1;
            bidx          <= '0;
          end
        end
        S_SHIFT: begin
          cnt   <= cnt_nx;
          rb_sh <= rb_sh_nx;
          rb_n  <= rb_n_nx;
          if (rb_n_nx == FULL_RB) begin
            rb_data  <= rb_sh_nx;
            rb_valid <= 1'b1;
            rb_n     <= '0;
          end else if (chain_end) begin
            // partial last word: left-justify, zero-pad
            rb_data  <= rb_sh_nx << (FULL_RB - rb_n_nx);
            rb_valid <= 1'b1;
          end
          if (chain_end) begin
            st            <= S_DONE;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
          end else if (!last_bit) begin
            bidx      <= bidx + BIT_W'(1);
            ccff_head <= sh[WORD_W-1];
            sh        <= sh << 1;
          end else if (cfg_valid) begin
            bidx      <= '0;
            ccff_head <= cfg_data[WORD_W-1];
            sh        <= cfg_data << 1;
          end else begin
            st            <= S_LOAD;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            bidx          <= '0;
          end
        end
        S_DONE:  st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 16- and 12-bit chains against a FIFO
// reference of chain contents, directed plus randomized loads.
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       pResetn;
  logic       start;
  logic       cfg_valid;
  logic       sel;
  logic [7:0] cfg_data;

  logic st16, st12, v16, v12;
  logic rdy16, rdy12, hd16, hd12, ce16, ce12;
  logic rbv16, rbv12, bz16, bz12, dn16, dn12;
  logic [7:0] rbd16, rbd12;
  logic [15:0] ch16;
  logic [11:0] ch12;
  logic [15:0] pre16;
  logic [11:0] pre12;
  logic do_pre;

  assign st16 = start & ~sel;
  assign st12 = start & sel;
  assign v16  = cfg_valid & ~sel;
  assign v12  = cfg_valid & sel;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
    .prog_clk(prog_clk), .pResetn(pResetn), .start(st16),
    .cfg_data(cfg_data), .cfg_valid(v16), .cfg_ready(rdy16),
    .ccff_head(hd16), .config_enable(ce16), .ccff_tail(ch16[15]),
    .rb_data(rbd16), .rb_valid(rbv16), .busy(bz16), .done(dn16)
  );

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u12 (
    .prog_clk(prog_clk), .pResetn(pResetn), .start(st12),
    .cfg_data(cfg_data), .cfg_valid(v12), .cfg_ready(rdy12),
    .ccff_head(hd12), .config_enable(ce12), .ccff_tail(ch12[11]),
    .rb_data(rbd12), .rb_valid(rbv12), .busy(bz12), .done(dn12)
  );

  // behavioural chains: advance one bit per enabled edge
  always @(posedge prog_clk) begin
    if (do_pre) begin
      ch16 <= pre16;
      ch12 <= pre12;
    end else begin
      if (ce16) ch16 <= {ch16[14:0], hd16};
      if (ce12) ch12 <= {ch12[10:0], hd12};
    end
  end

  logic       cur_rdy, cur_hd, cur_ce, cur_rbv, cur_bz, cur_dn;
  logic [7:0] cur_rbd;
  assign cur_rdy = sel ? rdy12 : rdy16;
  assign cur_hd  = sel ? hd12  : hd16;
  assign cur_ce  = sel ? ce12  : ce16;
  assign cur_rbv = sel ? rbv12 : rbv16;
  assign cur_bz  = sel ? bz12  : bz16;
  assign cur_dn  = sel ? dn12  : dn16;
  assign cur_rbd = sel ? rbd12 : rbd16;

  logic        mclr;
  int          m_ce, m_stall, m_done;
  logic [31:0] m_head;
  logic [7:0]  m_rb[$];

  always @(negedge prog_clk) begin
    if (mclr) begin
      m_ce = 0; m_stall = 0; m_done = 0; m_head = '0;
      m_rb.delete();
    end else begin
      if (cur_ce) begin
        m_head = {m_head[30:0], cur_hd};
        m_ce++;
      end
      if (cur_bz && !cur_ce) m_stall++;
      if (cur_rbv) m_rb.push_back(cur_rbd);
      if (cur_dn) m_done++;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit q16[$];
  bit q12[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic ref_shift(input bit b, output bit old);
    if (sel) begin
      old = q12.pop_front();
      q12.push_back(b);
    end else begin
      old = q16.pop_front();
      q16.push_back(b);
    end
  endtask

  function automatic logic [31:0] ref_vec();
    logic [31:0] v = '0;
    if (sel) foreach (q12[i]) v = {v[30:0], q12[i]};
    else     foreach (q16[i]) v = {v[30:0], q16[i]};
    return v;
  endfunction

  task automatic preload(input logic [15:0] a, input logic [11:0] b);
    pre16 = a;
    pre12 = b;
    q16.delete();
    q12.delete();
    for (int i = 15; i >= 0; i--) q16.push_back(a[i]);
    for (int i = 11; i >= 0; i--) q12.push_back(b[i]);
    @(posedge prog_clk);
    do_pre = 1'b1;
    @(posedge prog_clk);
    #1 do_pre = 1'b0;
  endtask

  task automatic clear_mon();
    @(posedge prog_clk);
    mclr = 1'b1;
    step();
    mclr = 1'b0;
  endtask

  task automatic send(input logic [7:0] w, input int gap, input int k);
    int t = 0;
    if (k > 0) begin
      while (!cur_rdy && t < 40) begin step(); t++; end
      for (int g = 0; g < gap; g++) step();
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    while (!cur_rdy && t < 80) begin step(); t++; end
    chk("ready_wait", 32'(t < 80), 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1,
                         input int gap, input bit mid);
    int n, c, t;
    bit b, ob;
    logic [7:0]  acc;
    logic [31:0] eh;
    logic [7:0]  erb[$];
    logic [7:0]  ws[2];
    ws[0] = w0;
    ws[1] = w1;
    n = sel ? 12 : 16;
    eh = '0; acc = '0; c = 0;
    for (int i = 0; i < n; i++) begin
      b = ws[i/8][7-(i%8)];
      eh = {eh[30:0], b};
      ref_shift(b, ob);
      acc = {acc[6:0], ob};
      c++;
      if (c == 8) begin erb.push_back(acc); c = 0; acc = '0; end
    end
    if (c > 0) erb.push_back(acc << (8 - c));

    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    send(w0, 0, 0);
    if (mid) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    send(w1, gap, 1);
    t = 0;
    while (m_done == 0 && t < 100) begin step(); t++; end
    repeat (3) step();

    chk("done_seen", 32'(t < 100), 32'd1);
    chk("ce_count", 32'(m_ce), 32'(n));
    chk("head_bits", m_head, eh);
    chk("stall_cycles", 32'(m_stall), 32'(1 + gap));
    chk("done_pulses", 32'(m_done), 32'd1);
    chk("rb_count", 32'(m_rb.size()), 32'(erb.size()));
    for (int i = 0; i < erb.size() && i < m_rb.size(); i++)
      chk($sformatf("rb_word%0d", i), 32'(m_rb[i]), 32'(erb[i]));
    chk("chain", sel ? 32'(ch12) : 32'(ch16), ref_vec());
  endtask

  initial begin
    logic [7:0] w;
    int t;
    pResetn   = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    sel       = 1'b0;
    mclr      = 1'b1;
    do_pre    = 1'b0;
    pre16     = '0;
    pre12     = '0;
    repeat (3) step();
    chk("rst_ce16", 32'(ce16), 32'd0);
    chk("rst_rdy16", 32'(rdy16), 32'd0);
    chk("rst_busy16", 32'(bz16), 32'd0);
    chk("rst_done16", 32'(dn16), 32'd0);
    chk("rst_head16", 32'(hd16), 32'd0);
    chk("rst_rb16", {23'd0, rbv16, rbd16}, 32'd0);
    chk("rst_busy12", 32'(bz12), 32'd0);
    chk("rst_rb12", {23'd0, rbv12, rbd12}, 32'd0);
    pResetn = 1'b1;
    mclr    = 1'b0;
    step();

    preload(16'hFFFF, 12'h5A3);
    sel = 1'b0;
    do_load(8'hA5, 8'h3C, 0, 0);
    chk("d16_head", m_head, 32'h0000_A53C);
    chk("d16_rb0", 32'(m_rb[0]), 32'hFF);
    chk("d16_rb1", 32'(m_rb[1]), 32'hFF);
    do_load(8'h00, 8'h00, 0, 0);
    chk("loop_rb0", 32'(m_rb[0]), 32'hA5);
    chk("loop_rb1", 32'(m_rb[1]), 32'h3C);

    sel = 1'b1;
    do_load(8'hAB, 8'hCD, 0, 0);
    chk("d12_head", m_head, 32'h0000_0ABC);
    do_load(8'h00, 8'h00, 0, 0);
    chk("d12_rb0", 32'(m_rb[0]), 32'hAB);
    chk("d12_rb1", 32'(m_rb[1]), 32'hC0);

    sel = 1'b0;
    do_load(8'h5E, 8'h77, 3, 0);
    chk("gap_chain", 32'(ch16), 32'h5E77);
    do_load(8'h19, 8'hE2, 0, 1);

    // abandon a load after five shifted bits
    w = 8'hC6;
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    send(w, 0, 0);
    t = 0;
    while (m_ce < 5 && t < 40) begin step(); t++; end
    @(posedge prog_clk);
    #2 pResetn = 1'b0;
    #1;
    chk("mid_rst_ce", 32'(ce16), 32'd0);
    chk("mid_rst_busy", 32'(bz16), 32'd0);
    chk("mid_rst_out", {22'd0, rdy16, hd16, rbv16, dn16, rbd16}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      bit ob;
      ref_shift(w[7-i], ob);
    end
    repeat (3) step();
    chk("mid_rst_shifts", 32'(m_ce), 32'd5);
    chk("mid_rst_done", 32'(m_done), 32'd0);
    chk("mid_rst_chain", 32'(ch16), ref_vec());
    pResetn = 1'b1;
    step();
    do_load(8'h96, 8'h0F, 0, 0);

    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom_range(0, 1));
      do_load(8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
